ov7670_emulator: RTL and testbench
==================================

OV7670_EMULATOR -- requirements
Module: ov7670_emulator

Interface
REQ-001 SHALL have parameters H_ACTIVE 640 pixels/line; V_ACTIVE 480 active lines; H_BLANK 144 PCLK of HREF-low per line; VSYNC_LINES 3; V_BACK 17 lines; V_FRONT 10 lines.
REQ-002 SHALL have ports:
- PCLK in 1: sole clock.
- Reset in 1: asynchronous, active-high.
- Enable in 1: permits the next frame to start.
- Pattern in 2: pattern select.
- VSYNC out 1: frame sync.
- HREF out 1: line valid.
- D out 8: pixel byte.
- FrameDone out 1: one-cycle end-of-frame pulse.
- FrameCount out 16: completed frames.
REQ-003 One clock; reset is asynchronous and active-high. Clock port is named PCLK and reset port is named Reset.

Function
REQ-004 SHALL emit OV7670 YUV422 DVP timing that the existing capture block accepts unmodified.
- Line period L = 2*H_ACTIVE + H_BLANK PCLK.
- Frame = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * L PCLK.
REQ-005 States and transitions:
- IDLE -> VS when Enable=1.
- VS -> VBACK after VSYNC_LINES*L cycles.
- VBACK -> ACTIVE after V_BACK*L cycles.
- ACTIVE -> VFRONT after V_ACTIVE*L cycles.
- VFRONT -> VS if Enable=1, else IDLE, after V_FRONT*L cycles.
REQ-006 VSYNC SHALL be 1 exactly while in VS. The first VS cycle is the cycle after Enable is sampled high in IDLE.
REQ-007 In ACTIVE, HREF SHALL be 1 for the first 2*H_ACTIVE cycles of each line and 0 for the remaining H_BLANK cycles. HREF SHALL be 0 in every other state.
REQ-008 While HREF=1, D SHALL repeat Cb,Y0,Cr,Y1 per pixel pair, starting with Cb on the HREF rising cycle. Cb = Cr = 8'h80. While HREF=0, D SHALL be 8'h00.
REQ-009 Y for pixel column x (0..H_ACTIVE-1) and active row y (0..V_ACTIVE-1):
- Pattern 0: Y = x[7:0] (ramp; wraps every 256 pixels).
- Pattern 1: Y = 8'hFF when x[3]^y[3], else 8'h00 (8x8 checkerboard).
- Pattern 2: Y = 8'hFF.
- Pattern 3: Y = 8'h00.
REQ-010 Pattern SHALL be latched on the first VS cycle of each frame. Changes mid-frame SHALL be ignored until the next frame.
REQ-011 Enable SHALL be sampled only in IDLE and on the last VFRONT cycle. Deassertion mid-frame SHALL let the current frame complete.
REQ-012 FrameDone SHALL be 1 for exactly the last VFRONT cycle of each frame. FrameCount SHALL increment on that same cycle and wrap from 16'hFFFF to 0.
REQ-013 Back-to-back frames SHALL have zero idle cycles: VS follows the last VFRONT cycle directly.
REQ-014 VSYNC, HREF and D SHALL be registered outputs, changing only on the PCLK rising edge.
REQ-015 Line and column counters SHALL be sized by $clog2 of their maximum parameter-derived count. Width overflow is not permitted.

Reset
REQ-016 Reset=1 SHALL asynchronously force: state IDLE; VSYNC 0; HREF 0; D 8'h00; FrameDone 0; FrameCount 0; all counters 0; latched Pattern 0.
REQ-017 Reset asserted mid-frame SHALL abort the frame with no FrameDone. After release, the block SHALL wait in IDLE for Enable.

Structure
REQ-018 Package ov7670_pkg SHALL hold the state enumeration, the pattern codes, and the CHROMA_NEUTRAL = 8'h80 constant. The existing capture block may import the same package.
REQ-019 Y generation (REQ-009) SHALL be a sub-module named ov7670_pattern_gen. Inputs: x, y, latched pattern. Output: Y byte. It is combinational and is registered in the parent.
REQ-020 The top level SHALL contain the state machine, the line/column counters, the byte-phase counter and the output registers.

Verification
Bench parameters: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. This gives L=11 and a frame of 55 cycles.
REQ-021 Enable=1, Pattern=0:
- VSYNC high exactly 11 cycles, starting one cycle after Enable.
- Each active line gives HREF high 8 cycles with D = 80,00,80,01,80,02,80,03, then HREF low 3 cycles with D = 00.
REQ-022 Pattern=2, Enable held: two frames back-to-back.
- FrameDone pulses at cycles 55 and 110 after the first VS.
- FrameCount = 2.
- Every Y byte = FF.
REQ-023 Pattern switched 0->2 mid-ACTIVE: the rest of that frame stays ramp; the next frame is all FF.
REQ-024 Enable dropped during VBACK: the frame completes with one FrameDone, then IDLE with VSYNC=0 and HREF=0 indefinitely.
REQ-025 Reset pulsed mid-line while HREF=1: HREF, D and VSYNC go to 0 immediately without waiting for a clock edge. FrameCount = 0 and no FrameDone.
REQ-026 Loopback: the emulator drives the existing capture block. With Pattern=1, the captured binary buffer matches the checkerboard at every written address.

Source files
------------

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and constants for the OV7670 DVP emulator
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VS     = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    localparam logic [1:0] PAT_RAMP    = 2'd0;
    localparam logic [1:0] PAT_CHECKER = 2'd1;
    localparam logic [1:0] PAT_WHITE   = 2'd2;
    localparam logic [1:0] PAT_BLACK   = 2'd3;

    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// rtl/ov7670_pattern_gen.sv - combinational luma generator for the test patterns
module ov7670_pattern_gen
    import ov7670_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    pattern,
    output logic [7:0]    y_byte
);

    logic       x_bit3;
    logic       y_bit3;
    logic [7:0] x_low;

    // Bit 3 of each coordinate selects the 8x8 checker cell; narrow counters read as zero there.
    assign x_bit3 = |(x & XW'(8));
    assign y_bit3 = |(y & YW'(8));
    assign x_low  = 8'(x);

    // Select the luma value for the latched pattern.
    always_comb begin
        y_byte = 8'h00;
        case (pattern)
            PAT_RAMP:    y_byte = x_low;
            PAT_CHECKER: y_byte = (x_bit3 ^ y_bit3) ? 8'hFF : 8'h00;
            PAT_WHITE:   y_byte = 8'hFF;
            PAT_BLACK:   y_byte = 8'h00;
            default:     y_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/ov7670_emulator.sv
// rtl/ov7670_emulator.sv - OV7670 YUV422 DVP timing and pattern source
module ov7670_emulator
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        PCLK,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [1:0]  Pattern,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  D,
    output logic        FrameDone,
    output logic [15:0] FrameCount
);

    localparam int L_CYC    = 2 * H_ACTIVE + H_BLANK;
    localparam int HREF_CYC = 2 * H_ACTIVE;
    localparam int MAX_AB   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_CD   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LINE_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int COL_W    = clog2_min1(L_CYC);
    localparam int LINE_W   = clog2_min1(LINE_MAX);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] last_line;
    logic              end_of_state;
    logic [1:0]        phase_q, phase_d;
    logic [1:0]        pat_q, pat_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic [15:0]       count_q, count_d;
    logic [7:0]        y_byte;

    // Luma for the position the outputs will show after the next edge.
    ov7670_pattern_gen #(
        .XW (COL_W - 1),
        .YW (LINE_W)
    ) u_pattern_gen (
        .x       (col_d[COL_W-1:1]),
        .y       (line_d),
        .pattern (pat_q),
        .y_byte  (y_byte)
    );

    // Frame state machine with column/line counters that restart in each state.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        line_d       = line_q;
        end_of_state = 1'b0;
        last_line    = '0;
        case (state_q)
            ST_VS:     last_line = LINE_W'(VSYNC_LINES - 1);
            ST_VBACK:  last_line = LINE_W'(V_BACK - 1);
            ST_ACTIVE: last_line = LINE_W'(V_ACTIVE - 1);
            ST_VFRONT: last_line = LINE_W'(V_FRONT - 1);
            default:   last_line = '0;
        endcase
        if (state_q == ST_IDLE) begin
            col_d  = '0;
            line_d = '0;
            if (Enable) begin
                state_d = ST_VS;
            end
        end else if (col_q == COL_W'(L_CYC - 1)) begin
            col_d = '0;
            if (line_q == last_line) begin
                line_d       = '0;
                end_of_state = 1'b1;
            end else begin
                line_d = line_q + 1'b1;
            end
        end else begin
            col_d = col_q + 1'b1;
        end
        if (end_of_state) begin
            case (state_q)
                ST_VS:     state_d = ST_VBACK;
                ST_VBACK:  state_d = ST_ACTIVE;
                ST_ACTIVE: state_d = ST_VFRONT;
                ST_VFRONT: state_d = Enable ? ST_VS : ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output values for the next cycle, decoded from the next-state position so the pins are pure flops.
    always_comb begin
        vsync_d = (state_d == ST_VS);
        href_d  = (state_d == ST_ACTIVE) && (int'(col_d) < HREF_CYC);
        phase_d = 2'd0;
        if (href_d && href_q) begin
            phase_d = phase_q + 2'd1;
        end
        data_d = 8'h00;
        if (href_d) begin
            data_d = phase_d[0] ? y_byte : CHROMA_NEUTRAL;
        end
        done_d  = (state_d == ST_VFRONT) && (line_d == LINE_W'(V_FRONT - 1))
                  && (col_d == COL_W'(L_CYC - 1));
        count_d = done_d ? count_q + 16'd1 : count_q;
        pat_d   = pat_q;
        if ((state_q == ST_VS) && (line_q == '0) && (col_q == '0)) begin
            pat_d = Pattern;
        end
    end

    // State, counters and output registers; reset aborts any frame in progress.
    always_ff @(posedge PCLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            phase_q <= 2'd0;
            pat_q   <= 2'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            phase_q <= phase_d;
            pat_q   <= pat_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign VSYNC      = vsync_q;
    assign HREF       = href_q;
    assign D          = data_q;
    assign FrameDone  = done_q;
    assign FrameCount = count_q;

endmodule

// File: tb/tb_ov7670_emulator.sv
// tb/tb_ov7670_emulator.sv - scoreboard bench for the OV7670 emulator
module tb_ov7670_emulator;

    logic        PCLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic [1:0]  Pattern = 2'd0;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  D;
    logic        FrameDone;
    logic [15:0] FrameCount;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    ov7670_emulator #(
        .H_ACTIVE    (4),
        .V_ACTIVE    (2),
        .H_BLANK     (3),
        .VSYNC_LINES (1),
        .V_BACK      (1),
        .V_FRONT     (1)
    ) dut (
        .PCLK       (PCLK),
        .Reset      (Reset),
        .Enable     (Enable),
        .Pattern    (Pattern),
        .VSYNC      (VSYNC),
        .HREF       (HREF),
        .D          (D),
        .FrameDone  (FrameDone),
        .FrameCount (FrameCount)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [7:0] exp_y(input int pat, input int x, input int y);
        case (pat)
            0:       return 8'(x);
            1:       return (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            2:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_frame(input int pat);
        for (int y = 0; y < 2; y++) begin
            for (int c = 0; c < 8; c++) begin
                if (c % 2 == 0) exp_q.push_back(8'h80);
                else            exp_q.push_back(exp_y(pat, c / 2, y));
            end
        end
    endtask

    // Scoreboard: every HREF byte is popped and compared; blanking must carry zero.
    always @(negedge PCLK) begin
        if (!Reset) begin
            n_checks++;
            if (HREF === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got D=%h, no byte expected", D);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (D !== e) begin
                        n_fail++;
                        $display("FAIL sb_byte: got D=%h, expected %h", D, e);
                    end
                end
            end else if (D !== 8'h00) begin
                n_fail++;
                $display("FAIL sb_blank: got D=%h with HREF=%b, expected 00", D, HREF);
            end
        end
    end

    task automatic do_reset();
        @(negedge PCLK);
        Reset  = 1'b1;
        Enable = 1'b0;
        @(negedge PCLK);
        exp_q.delete();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge PCLK);
        n_checks++;
        if ({VSYNC, HREF, D, FrameDone, FrameCount} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_state: got vs=%b href=%b d=%h done=%b cnt=%0d, expected all 0",
                     VSYNC, HREF, D, FrameDone, FrameCount);
        end
    endtask

    task automatic test_ramp();
        logic e_vs, e_href, e_done;
        do_reset();
        Pattern = 2'd0;
        push_frame(0);
        Enable = 1'b1;
        for (int i = 1; i <= 62; i++) begin
            @(negedge PCLK);
            if (i == 2) Enable = 1'b0;
            e_vs   = (i >= 1) && (i <= 11);
            e_href = (i >= 23) && (i <= 44) && (((i - 23) % 11) < 8);
            e_done = (i == 55);
            n_checks++;
            if ({VSYNC, HREF, FrameDone} !== {e_vs, e_href, e_done}) begin
                n_fail++;
                $display("FAIL ramp_timing cycle %0d: got vs/href/done=%b%b%b, expected %b%b%b",
                         i, VSYNC, HREF, FrameDone, e_vs, e_href, e_done);
            end
        end
        n_checks++;
        if (FrameCount !== 16'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ramp_end: got cnt=%0d left=%0d, expected cnt=1 left=0", FrameCount, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int first, second, extra;
        first = 0; second = 0; extra = 0;
        do_reset();
        Pattern = 2'd2;
        push_frame(2);
        push_frame(2);
        Enable = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            @(negedge PCLK);
            if (i == 60) Enable = 1'b0;
            if (FrameDone === 1'b1) begin
                if (first == 0)       first = i;
                else if (second == 0) second = i;
                else                  extra++;
            end
            if (i == 56 || i == 115) begin
                n_checks++;
                if (VSYNC !== (i == 56)) begin
                    n_fail++;
                    $display("FAIL b2b_vsync cycle %0d: got %b, expected %b", i, VSYNC, (i == 56));
                end
            end
        end
        n_checks++;
        if (first != 55 || second != 110 || extra != 0) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d,%0d (+%0d), expected 55,110 (+0)", first, second, extra);
        end
        n_checks++;
        if (FrameCount !== 16'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_end: got cnt=%0d left=%0d, expected cnt=2 left=0", FrameCount, exp_q.size());
        end
    endtask

    task automatic test_pattern_switch();
        do_reset();
        Pattern = 2'd0;
        push_frame(0);
        push_frame(2);
        Enable = 1'b1;
        for (int i = 1; i <= 115; i++) begin
            @(negedge PCLK);
            if (i == 26) Pattern = 2'd2;
            if (i == 60) Enable = 1'b0;
        end
        n_checks++;
        if (FrameCount !== 16'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL switch_end: got cnt=%0d left=%0d, expected cnt=2 left=0", FrameCount, exp_q.size());
        end
    endtask

    task automatic test_enable_drop();
        int dones;
        dones = 0;
        do_reset();
        Pattern = 2'd3;
        push_frame(3);
        Enable = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge PCLK);
            if (i == 15) Enable = 1'b0;
            if (FrameDone === 1'b1) dones++;
            if (i > 55) begin
                n_checks++;
                if (VSYNC !== 1'b0 || HREF !== 1'b0) begin
                    n_fail++;
                    $display("FAIL drop_idle cycle %0d: got vs=%b href=%b, expected 0 0", i, VSYNC, HREF);
                end
            end
        end
        n_checks++;
        if (dones != 1 || FrameCount !== 16'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drop_end: got dones=%0d cnt=%0d left=%0d, expected 1 1 0",
                     dones, FrameCount, exp_q.size());
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        Pattern = 2'd0;
        push_frame(0);
        Enable = 1'b1;
        for (int i = 1; i <= 25; i++) @(negedge PCLK);
        n_checks++;
        if (HREF !== 1'b1) begin
            n_fail++;
            $display("FAIL midline_pre: got HREF=%b, expected 1", HREF);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({VSYNC, HREF, D, FrameDone, FrameCount} !== 27'd0) begin
            n_fail++;
            $display("FAIL midline_async: got vs=%b href=%b d=%h done=%b cnt=%0d, expected all 0",
                     VSYNC, HREF, D, FrameDone, FrameCount);
        end
        exp_q.delete();
        Enable = 1'b0;
        @(negedge PCLK);
        Reset = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge PCLK);
            n_checks++;
            if (FrameDone !== 1'b0 || VSYNC !== 1'b0) begin
                n_fail++;
                $display("FAIL midline_after cycle %0d: got done=%b vs=%b, expected 0 0", i, FrameDone, VSYNC);
            end
        end
        n_checks++;
        if (FrameCount !== 16'd0) begin
            n_fail++;
            $display("FAIL midline_count: got %0d, expected 0", FrameCount);
        end
    endtask

    task automatic test_loopback_checker();
        logic cap[2][4];
        logic wr[2][4];
        int row, col, nwr;
        logic prev_href;
        row = -1; col = 0; nwr = 0; prev_href = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int x = 0; x < 4; x++) begin
                cap[r][x] = 1'b0;
                wr[r][x]  = 1'b0;
            end
        do_reset();
        Pattern = 2'd1;
        push_frame(1);
        Enable = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge PCLK);
            if (i == 2) Enable = 1'b0;
            if (HREF === 1'b1 && !prev_href) begin
                row++;
                col = 0;
            end
            if (HREF === 1'b1 && row >= 0 && row < 2 && col < 8) begin
                if (col % 2 == 1) begin
                    cap[row][col / 2] = (D == 8'hFF);
                    wr[row][col / 2]  = 1'b1;
                end
                col++;
            end
            prev_href = (HREF === 1'b1);
        end
        for (int r = 0; r < 2; r++)
            for (int x = 0; x < 4; x++)
                if (wr[r][x]) begin
                    nwr++;
                    n_checks++;
                    if (cap[r][x] !== (x[3] ^ r[3])) begin
                        n_fail++;
                        $display("FAIL loopback_buf[%0d][%0d]: got %b, expected %b", r, x, cap[r][x], (x[3] ^ r[3]));
                    end
                end
        n_checks++;
        if (nwr != 8 || row != 1) begin
            n_fail++;
            $display("FAIL loopback_coverage: got %0d writes over %0d rows, expected 8 over 2", nwr, row + 1);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_pattern_switch();
        test_enable_drop();
        test_reset_midline();
        test_loopback_checker();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
